neuron_seq_ctrl: RTL and testbench
==================================

Name: neuron_seq_ctrl

Overview:
Time-multiplexed sequencer for a single neuron. It fetches NUM input/weight pairs one per cycle from an external dual-port operand store and runs each pair through one shared multiplier and accumulator. It then applies the sign-step activation ({acc MSB, zeros}) and presents the result over a valid/ready handshake. It replaces the fully parallel NUM-multiplier neuron wherever area matters more than latency.

Parameters:
WIDTH, 13, datapath width of inputs, weights, products, accumulator and result
NUM, 13, number of input/weight pairs per evaluation; legal range 2..1024
ADDR_W, $clog2(NUM), operand-store address width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request evaluation; sampled only in IDLE
busy  out  1  high in every state except IDLE
rd_en  out  1  operand-store read strobe
rd_addr  out  ADDR_W  operand index 0..NUM-1
in_data  in  WIDTH  input operand, valid one cycle after rd_en
w_data  in  WIDTH  weight operand, valid one cycle after rd_en
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out  out  WIDTH  activated result; stable while out_valid is high

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; busy, rd_en, rd_addr, out_valid, out and the accumulator all go to 0. Reset takes effect in any state and aborts any evaluation in progress; no partial result is ever emitted.
- FSM states are IDLE, RUN, DRAIN, DONE.
- IDLE: when start=1, clear the accumulator, set rd_addr=0, rd_en=1, and move to RUN.
- RUN: lasts exactly NUM cycles with rd_en=1 and rd_addr incrementing 0..NUM-1.
  - In every RUN cycle after the first, acc <= acc + (in_data*w_data).
  - After the cycle with rd_addr=NUM-1, go to DRAIN. rd_addr does not wrap.
- DRAIN: rd_en=0; accumulate the final pair; go to DONE.
- DONE: out={acc[WIDTH-1], (WIDTH-1)'b0} and out_valid=1. Hold both until out_ready=1, then go to IDLE with out_valid=0 on the next cycle.
- Latency: start accepted at cycle 0 puts out_valid high at cycle NUM+2. Minimum start-to-start spacing is NUM+3 cycles.
- start while busy is ignored and not queued. start arriving in the same cycle as the DONE handshake is ignored.
- out_ready outside DONE has no effect.
- Arithmetic: the product is truncated to its low WIDTH bits. Accumulation wraps modulo 2^WIDTH (default build). All values are two's complement for activation purposes.

Optional Feature:
Macro: NEURON_SAT_EN
- Defined: the product is still truncated to WIDTH bits, but accumulation saturates as signed WIDTH-bit.
  - Positive overflow clamps to 2^(WIDTH-1)-1.
  - Negative overflow clamps to -2^(WIDTH-1).
  - Saturation is sticky only through arithmetic: later terms may move the value back off the rail.
- Undefined: plain wrap-around accumulation. No extra ports in either build.

Decomposition:
- Package neuron_pkg holds:
  - default WIDTH and NUM constants;
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - an activation function returning {msb, zeros}.
- Sub-module neuron_mac: multiplier, accumulator register, clear/enable inputs, and the NEURON_SAT_EN saturation logic.
- The controller keeps the FSM, address counter and handshake.

Test Plan:
1. All in=1, w=1, NUM=13, start pulse -> acc=13; out_valid at cycle 15 with out=0; rd_addr sequence 0..12 with no gaps.
2. All in=1, w=8191 (-1) -> acc=8179; out=4096 (0x1000).
3. in[0..1]=1000, w[0..1]=4, others w=0 -> wrap build: acc=8000, out=4096; NEURON_SAT_EN build: acc=4095, out=0.
4. Hold out_ready=0 for 5 cycles in DONE, pulse start meanwhile -> out and out_valid stable, start ignored; out_ready=1 -> IDLE next cycle, busy=0.
5. rst_n=0 during RUN at rd_addr=5 -> next cycle all outputs 0 and state IDLE; rerun of scenario 1 gives out=0 with acc exactly 13 (no residue).
6. Back-to-back evaluations with start held high continuously -> second evaluation begins exactly NUM+3 cycles after the first start and produces an identical result.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared constants, FSM state type and sign-step activation for the neuron sequencer.
package neuron_pkg;

    localparam int WIDTH_DEF = 13;
    localparam int NUM_DEF   = 13;
    localparam int ACT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Returns {msb, zeros} right-aligned in ACT_MAX_W bits; callers cast down to their width.
    function automatic logic [ACT_MAX_W-1:0] activate(input logic msb, input int width);
        activate = ACT_MAX_W'(msb) << (width - 1);
    endfunction

endpackage

// File: rtl/neuron_seq_ctrl_if.sv
// Operand-store read port, start/busy control and result handshake of the neuron sequencer.
interface neuron_seq_ctrl_if #(
    parameter int WIDTH = neuron_pkg::WIDTH_DEF,
    parameter int NUM   = neuron_pkg::NUM_DEF
);
    localparam int ADDR_W = (NUM > 1) ? $clog2(NUM) : 1;

    logic                  start;
    logic                  busy;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [WIDTH-1:0]      in_data;
    logic [WIDTH-1:0]      w_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out;
    neuron_pkg::state_t    state;

    // Result transfers on a rising edge where out_valid && out_ready; until then
    // out_valid stays high and out is stable. Operands arrive the cycle after rd_en.
    modport master (
        output start, in_data, w_data, out_ready,
        input  busy, rd_en, rd_addr, out_valid, out, state
    );

    modport slave (
        input  start, in_data, w_data, out_ready,
        output busy, rd_en, rd_addr, out_valid, out, state
    );

endinterface

// File: rtl/neuron_mac.sv
// Shared multiplier and accumulator; NEURON_SAT_EN selects signed saturating accumulation.
module neuron_mac #(
    parameter int WIDTH = neuron_pkg::WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc
);

    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] acc_next;

    // Low WIDTH bits are identical for signed and unsigned multiplication.
    assign prod = a * b;

`ifdef NEURON_SAT_EN
    localparam logic [WIDTH-1:0] POS_RAIL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_RAIL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] sum;

    assign sum = {prod[WIDTH-1], prod} + {acc[WIDTH-1], acc};

    always_comb begin
        acc_next = sum[WIDTH-1:0];
        if (sum[WIDTH] != sum[WIDTH-1]) begin
            acc_next = sum[WIDTH] ? NEG_RAIL : POS_RAIL;
        end
    end
`else
    assign acc_next = acc + prod;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/neuron_seq_ctrl.sv
// Time-multiplexed single-neuron sequencer: fetch NUM pairs, MAC, sign-step, handshake out.
// Saturating accumulation is enabled by defining NEURON_SAT_EN.
module neuron_seq_ctrl
    import neuron_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NUM   = NUM_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    neuron_seq_ctrl_if.slave bus
);

    localparam int ADDR_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM - 1);

    state_t            state;
    state_t            state_next;
    logic              rd_en_q;
    logic              rd_en_next;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] rd_addr_next;
    logic              acc_clear;
    logic              acc_en;
    logic [WIDTH-1:0]  acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state     <= state_next;
            rd_en_q   <= rd_en_next;
            rd_addr_q <= rd_addr_next;
        end
    end

    // Operands lag rd_en by one cycle, so the MAC skips the first RUN cycle
    // and picks up the last pair in DRAIN.
    always_comb begin
        state_next   = state;
        rd_en_next   = 1'b0;
        rd_addr_next = rd_addr_q;
        acc_clear    = 1'b0;
        acc_en       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next   = RUN;
                    rd_en_next   = 1'b1;
                    rd_addr_next = '0;
                    acc_clear    = 1'b1;
                end
            end
            RUN: begin
                acc_en = (rd_addr_q != '0);
                if (rd_addr_q == LAST_ADDR) begin
                    state_next = DRAIN;
                end else begin
                    rd_en_next   = 1'b1;
                    rd_addr_next = rd_addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                acc_en     = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    neuron_mac #(.WIDTH(WIDTH)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (acc_clear),
        .en    (acc_en),
        .a     (bus.in_data),
        .b     (bus.w_data),
        .acc   (acc)
    );

    assign bus.busy      = (state != IDLE);
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_valid = (state == DONE);
    assign bus.out       = (state == DONE) ? WIDTH'(activate(acc[WIDTH-1], WIDTH)) : '0;
    assign bus.state     = state;

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Self-checking bench for neuron_seq_ctrl: directed scenarios plus randomized evaluations.
module tb_neuron_seq_ctrl;

    localparam int WIDTH      = 13;
    localparam int NUM        = 13;
    localparam int ADDR_W     = $clog2(NUM);
    localparam int CYC_BUDGET = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_seq_ctrl_if #(.WIDTH(WIDTH), .NUM(NUM)) bus ();

    neuron_seq_ctrl #(.WIDTH(WIDTH), .NUM(NUM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [WIDTH-1:0] in_mem [NUM];
    logic [WIDTH-1:0] w_mem  [NUM];

    // External operand store: registered read, data one cycle after rd_en.
    always @(posedge clk) begin
        if (!rst_n) begin
            bus.in_data <= '0;
            bus.w_data  <= '0;
        end else if (bus.rd_en) begin
            bus.in_data <= in_mem[bus.rd_addr];
            bus.w_data  <= w_mem[bus.rd_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: sum of truncated products, wrapping or saturating as signed WIDTH bits.
    function automatic logic [WIDTH-1:0] ref_eval();
        int s;
        s = 0;
        for (int k = 0; k < NUM; k++) begin
            logic [WIDTH-1:0] pt;
            pt = WIDTH'(int'(in_mem[k]) * int'(w_mem[k]));
`ifdef NEURON_SAT_EN
            s = s + int'($signed(pt));
            if (s > (1 << (WIDTH-1)) - 1) s = (1 << (WIDTH-1)) - 1;
            if (s < -(1 << (WIDTH-1)))    s = -(1 << (WIDTH-1));
`else
            s = (s + int'(pt)) % (1 << WIDTH);
`endif
        end
        return WIDTH'(s);
    endfunction

    function automatic logic [WIDTH-1:0] ref_act(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(1 << (WIDTH-1)) : '0;
    endfunction

    // Model: m_t counts cycles since an accepted start (0 = idle, NUM+2 = result held).
    int                m_t      = 0;
    logic [ADDR_W-1:0] m_addr   = '0;
    logic [WIDTH-1:0]  m_acc    = '0;
    bit                model_on = 1'b0;

    always @(posedge clk) begin
        model_on = 1'b1;
        if (!rst_n) begin
            m_t    = 0;
            m_addr = '0;
        end else if (m_t == 0) begin
            if (bus.start) begin
                m_t    = 1;
                m_addr = '0;
                m_acc  = ref_eval();
            end
        end else if (m_t < NUM + 2) begin
            m_t = m_t + 1;
            if (m_t <= NUM) m_addr = ADDR_W'(m_t - 1);
        end else if (bus.out_ready) begin
            m_t = 0;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("busy",      bus.busy,      m_t != 0);
            check("rd_en",     bus.rd_en,     (m_t >= 1) && (m_t <= NUM));
            check("rd_addr",   bus.rd_addr,   m_addr);
            check("out_valid", bus.out_valid, m_t == NUM + 2);
            check("out",       bus.out,       (m_t == NUM + 2) ? ref_act(m_acc) : '0);
            if (m_t == NUM + 2) check("acc", dut.u_mac.acc, m_acc);
        end
    end

    task automatic fill_mem(input logic [WIDTH-1:0] iv, input logic [WIDTH-1:0] wv);
        for (int k = 0; k < NUM; k++) begin
            in_mem[k] = iv;
            w_mem[k]  = wv;
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < CYC_BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) begin
            checks++;
            failures++;
            $display("FAIL wait_valid actual=timeout_after_%0d expected=valid_within_%0d", n, NUM + 2);
        end
    endtask

    task automatic accept(input int delay);
        repeat (delay) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_eval(input int delay, output logic [WIDTH-1:0] res,
                            output int lat, output logic [WIDTH-1:0] acc_v);
        int n;
        start_pulse();
        wait_valid(n);
        lat   = n + 1;
        res   = bus.out;
        acc_v = dut.u_mac.acc;
        accept(delay);
    endtask

    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] acc_v;
    logic [WIDTH-1:0] res_b2b [2];
    int               start_cyc [2];
    int               lat;
    int               n;

    initial begin
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        fill_mem(13'd1, 13'd1);
        repeat (2) @(negedge clk);
        check("rst_busy",      bus.busy,      0);
        check("rst_rd_en",     bus.rd_en,     0);
        check("rst_rd_addr",   bus.rd_addr,   0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out",       bus.out,       0);
        check("rst_acc",       dut.u_mac.acc, 0);
        rst_n = 1'b1;

        // All ones: acc 13, positive so out 0, valid at cycle NUM+2.
        check("s1_model", ref_eval(), 13);
        run_eval(0, res, lat, acc_v);
        check("s1_latency", lat, 15);
        check("s1_acc", acc_v, 13);
        check("s1_out", res, 0);

        // Weights -1: acc -13.
        fill_mem(13'd1, 13'd8191);
        check("s2_model", ref_eval(), 8179);
        run_eval(2, res, lat, acc_v);
        check("s2_acc", acc_v, 8179);
        check("s2_out", res, 13'h1000);

        // Two large terms overflow the signed range.
        fill_mem(13'd1, 13'd0);
        in_mem[0] = 13'd1000; in_mem[1] = 13'd1000;
        w_mem[0]  = 13'd4;    w_mem[1]  = 13'd4;
        run_eval(1, res, lat, acc_v);
`ifdef NEURON_SAT_EN
        check("s3_model", ref_eval(), 4095);
        check("s3_acc", acc_v, 4095);
        check("s3_out", res, 0);
`else
        check("s3_model", ref_eval(), 8000);
        check("s3_acc", acc_v, 8000);
        check("s3_out", res, 13'h1000);
`endif

        // Backpressure in DONE with a start pulse and a start on the handshake cycle.
        fill_mem(13'd1, 13'd8191);
        start_pulse();
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 2);
            @(negedge clk);
            check("s4_hold_valid", bus.out_valid, 1);
            check("s4_hold_out", bus.out, 13'h1000);
        end
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        check("s4_idle_busy", bus.busy, 0);
        check("s4_idle_valid", bus.out_valid, 0);
        @(negedge clk);
        check("s4_no_queued_start", bus.busy, 0);

        // Reset in the middle of RUN, then a clean rerun.
        fill_mem(13'd1, 13'd1);
        start_pulse();
        n = 0;
        while (bus.rd_addr != ADDR_W'(5) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("s5_reached_addr5", bus.rd_addr, 5);
        rst_n = 1'b0;
        @(negedge clk);
        check("s5_busy", bus.busy, 0);
        check("s5_rd_en", bus.rd_en, 0);
        check("s5_rd_addr", bus.rd_addr, 0);
        check("s5_out_valid", bus.out_valid, 0);
        check("s5_out", bus.out, 0);
        check("s5_acc", dut.u_mac.acc, 0);
        rst_n = 1'b1;
        run_eval(0, res, lat, acc_v);
        check("s5_rerun_acc", acc_v, 13);
        check("s5_rerun_out", res, 0);

        // start and out_ready held high: evaluations back to back.
        fill_mem(13'd1, 13'd8191);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        begin
            int ns, nr;
            ns = 0; nr = 0; n = 0;
            while (nr < 2 && n < 4 * (NUM + 3)) begin
                @(negedge clk);
                n++;
                if (bus.rd_en && bus.rd_addr == '0 && ns < 2) begin
                    start_cyc[ns] = cyc;
                    ns++;
                end
                if (bus.out_valid) begin
                    res_b2b[nr] = bus.out;
                    nr++;
                    if (nr == 2) bus.start = 1'b0;
                end
            end
            bus.start = 1'b0;
            check("s6_results_seen", nr, 2);
            check("s6_spacing", start_cyc[1] - start_cyc[0], 16);
            check("s6_first_out", res_b2b[0], 13'h1000);
            check("s6_second_out", res_b2b[1], 13'h1000);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Randomized evaluations, checked cycle by cycle against the model.
        for (int it = 0; it < 14; it++) begin
            for (int k = 0; k < NUM; k++) begin
                in_mem[k] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
                w_mem[k]  = (it < 4) ? WIDTH'($urandom_range(0, 7))
                                     : WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_eval($urandom_range(0, 4), res, lat, acc_v);
            check("rand_latency", lat, NUM + 2);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
